// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the control unit, its register file and the ALU.
//   - opcode constants (same encoding the ula block decodes)
//   - FSM state encoding of unidade_controle
//   - instruction field positions and immediate widths
//   - register address width and register count
package cpu_pkg;

    localparam int LARGURA_INSTR  = 16;
    localparam int LARGURA_OPCODE = 3;
    localparam int LARGURA_END    = 3;
    localparam int NUM_REGS       = 1 << LARGURA_END;

    // Instruction fields: [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2.
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 10;
    localparam int RS1_MSB = 9;
    localparam int RS1_LSB = 7;
    localparam int RS2_MSB = 6;
    localparam int RS2_LSB = 4;

    // Immediates are right-aligned and sign-extended from their top bit.
    localparam int IMM7_W  = 7;
    localparam int IMM10_W = 10;

    localparam logic [LARGURA_OPCODE-1:0] OP_LOAD = 3'b000;
    localparam logic [LARGURA_OPCODE-1:0] OP_ADD  = 3'b001;
    localparam logic [LARGURA_OPCODE-1:0] OP_ADDI = 3'b010;
    localparam logic [LARGURA_OPCODE-1:0] OP_SUB  = 3'b011;
    localparam logic [LARGURA_OPCODE-1:0] OP_SUBI = 3'b100;
    localparam logic [LARGURA_OPCODE-1:0] OP_MUL  = 3'b101;

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        DECODIFICA = 2'd1,
        EXECUTA    = 2'd2,
        ESCRITA    = 2'd3
    } estado_t;

endpackage

// File: rtl/banco_registradores.sv
// banco_registradores: 8 x LARGURA register file.
//   clk, reset          : clock, synchronous active-high clear of every register
//   escrita_hab/_end/_dado : synchronous write port
//   rs1_end/rs1_dado, rs2_end/rs2_dado : combinational operand read ports
//   debug_end/debug_dado : combinational debug read port (returns the old
//                          value when the same register is written this cycle)
module banco_registradores
    import cpu_pkg::*;
#(
    parameter int LARGURA = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   escrita_hab,
    input  logic [LARGURA_END-1:0] escrita_end,
    input  logic [LARGURA-1:0]     escrita_dado,
    input  logic [LARGURA_END-1:0] rs1_end,
    output logic [LARGURA-1:0]     rs1_dado,
    input  logic [LARGURA_END-1:0] rs2_end,
    output logic [LARGURA-1:0]     rs2_dado,
    input  logic [LARGURA_END-1:0] debug_end,
    output logic [LARGURA-1:0]     debug_dado
);

    logic [LARGURA-1:0] regs [NUM_REGS];

    // NOTE: the array is cleared on reset because reset must leave every
    // architectural register at zero; this keeps it as flops, not a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (escrita_hab) begin
            regs[escrita_end] <= escrita_dado;
        end
    end

    assign rs1_dado   = regs[rs1_end];
    assign rs2_dado   = regs[rs2_end];
    assign debug_dado = regs[debug_end];

endmodule

// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle issue/decode/write-back control for the ula block.
//   clk, reset                : clock, synchronous active-high reset
//   instr_valido/instrucao    : instruction input, taken when instr_pronto=1
//   instr_pronto              : high only while idle
//   ula_opcode/ula_valor1/2   : registered ALU operands, held outside EXECUTA
//   ula_resultado/ula_executou: combinational ALU response, sampled in EXECUTA
//   concluido / erro_opcode   : one-cycle completion / rejected-opcode pulses
//   wb_destino/wb_valor       : rd and value of the last completed instruction
//   leitura_end/leitura_dado  : combinational debug read of the register file
// Flow: accept (c0) -> DECODIFICA (c1) -> EXECUTA (c2) -> ESCRITA (c3).
module unidade_controle
    import cpu_pkg::*;
#(
    parameter int LARGURA = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      instr_valido,
    input  logic [LARGURA_INSTR-1:0]  instrucao,
    output logic                      instr_pronto,
    output logic [LARGURA_OPCODE-1:0] ula_opcode,
    output logic signed [LARGURA-1:0] ula_valor1,
    output logic signed [LARGURA-1:0] ula_valor2,
    input  logic signed [LARGURA-1:0] ula_resultado,
    input  logic                      ula_executou,
    output logic                      concluido,
    output logic                      erro_opcode,
    output logic [LARGURA_END-1:0]    wb_destino,
    output logic [LARGURA-1:0]        wb_valor,
    input  logic [LARGURA_END-1:0]    leitura_end,
    output logic [LARGURA-1:0]        leitura_dado
);

    estado_t estado, estado_prox;

    logic [LARGURA_INSTR-1:0]  instr_reg;
    logic                      captura_instr;
    logic                      registra_operandos;
    logic                      amostra_resultado;
    logic                      escreve;

    logic [LARGURA_OPCODE-1:0] campo_opcode;
    logic [LARGURA_END-1:0]    campo_rd;
    logic [LARGURA_END-1:0]    campo_rs1;
    logic [LARGURA_END-1:0]    campo_rs2;
    logic [LARGURA-1:0]        imm7_ext;
    logic [LARGURA-1:0]        imm10_ext;
    logic [LARGURA-1:0]        dado_rs1;
    logic [LARGURA-1:0]        dado_rs2;
    logic [LARGURA-1:0]        operando1;
    logic [LARGURA-1:0]        operando2;

    assign campo_opcode = instr_reg[OP_MSB:OP_LSB];
    assign campo_rd     = instr_reg[RD_MSB:RD_LSB];
    assign campo_rs1    = instr_reg[RS1_MSB:RS1_LSB];
    assign campo_rs2    = instr_reg[RS2_MSB:RS2_LSB];
    assign imm7_ext     = {{(LARGURA-IMM7_W){instr_reg[IMM7_W-1]}}, instr_reg[IMM7_W-1:0]};
    assign imm10_ext    = {{(LARGURA-IMM10_W){instr_reg[IMM10_W-1]}}, instr_reg[IMM10_W-1:0]};

    // The write port is fed from wb_*, which are captured when leaving EXECUTA,
    // so the register updates at the end of ESCRITA and is readable from c4.
    banco_registradores #(.LARGURA(LARGURA)) u_banco (
        .clk          (clk),
        .reset        (reset),
        .escrita_hab  (escreve),
        .escrita_end  (wb_destino),
        .escrita_dado (wb_valor),
        .rs1_end      (campo_rs1),
        .rs1_dado     (dado_rs1),
        .rs2_end      (campo_rs2),
        .rs2_dado     (dado_rs2),
        .debug_end    (leitura_end),
        .debug_dado   (leitura_dado)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        estado_prox        = estado;
        captura_instr      = 1'b0;
        registra_operandos = 1'b0;
        amostra_resultado  = 1'b0;
        escreve            = 1'b0;
        unique case (estado)
            OCIOSO: begin
                if (instr_valido) begin
                    captura_instr = 1'b1;
                    estado_prox   = DECODIFICA;
                end
            end
            DECODIFICA: begin
                registra_operandos = 1'b1;
                estado_prox        = EXECUTA;
            end
            EXECUTA: begin
                amostra_resultado = 1'b1;
                estado_prox       = ula_executou ? ESCRITA : OCIOSO;
            end
            ESCRITA: begin
                escreve     = 1'b1;
                estado_prox = OCIOSO;
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    assign instr_pronto = (estado == OCIOSO);

    // Operand selection; undefined opcodes fall back to the register pair.
    always_comb begin
        operando1 = dado_rs1;
        operando2 = dado_rs2;
        case (campo_opcode)
            OP_LOAD: begin
                operando1 = '0;
                operando2 = imm10_ext;
            end
            OP_ADDI, OP_SUBI: operando2 = imm7_ext;
            OP_ADD, OP_SUB, OP_MUL: begin
                operando1 = dado_rs1;
                operando2 = dado_rs2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_reg   <= '0;
            ula_opcode  <= '0;
            ula_valor1  <= '0;
            ula_valor2  <= '0;
            concluido   <= 1'b0;
            erro_opcode <= 1'b0;
            wb_destino  <= '0;
            wb_valor    <= '0;
        end else begin
            // Both pulses are decided by the single EXECUTA sample, so they
            // are mutually exclusive and last exactly one cycle.
            concluido   <= amostra_resultado && ula_executou;
            erro_opcode <= amostra_resultado && !ula_executou;
            if (captura_instr) begin
                instr_reg <= instrucao;
            end
            if (registra_operandos) begin
                ula_opcode <= campo_opcode;
                ula_valor1 <= operando1;
                ula_valor2 <= operando2;
            end
            if (amostra_resultado && ula_executou) begin
                wb_destino <= campo_rd;
                wb_valor   <= ula_resultado;
            end
        end
    end

endmodule

// File: tb/tb_unidade_controle.sv
module tb_unidade_controle;

    logic               clk;
    logic               reset;
    logic               instr_valido;
    logic [15:0]        instrucao;
    logic               instr_pronto;
    logic [2:0]         ula_opcode;
    logic signed [15:0] ula_valor1;
    logic signed [15:0] ula_valor2;
    logic signed [15:0] ula_resultado;
    logic               ula_executou;
    logic               concluido;
    logic               erro_opcode;
    logic [2:0]         wb_destino;
    logic [15:0]        wb_valor;
    logic [2:0]         leitura_end;
    logic [15:0]        leitura_dado;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference register file, updated only from instruction semantics.
    logic [15:0] mregs [8];

    unidade_controle #(.LARGURA(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valido  (instr_valido),
        .instrucao     (instrucao),
        .instr_pronto  (instr_pronto),
        .ula_opcode    (ula_opcode),
        .ula_valor1    (ula_valor1),
        .ula_valor2    (ula_valor2),
        .ula_resultado (ula_resultado),
        .ula_executou  (ula_executou),
        .concluido     (concluido),
        .erro_opcode   (erro_opcode),
        .wb_destino    (wb_destino),
        .wb_valor      (wb_valor),
        .leitura_end   (leitura_end),
        .leitura_dado  (leitura_dado)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Stand-in for the ula block.
    always_comb begin
        ula_executou  = 1'b1;
        ula_resultado = '0;
        case (ula_opcode)
            3'd0, 3'd1, 3'd2: ula_resultado = ula_valor1 + ula_valor2;
            3'd3, 3'd4:       ula_resultado = ula_valor1 - ula_valor2;
            3'd5:             ula_resultado = ula_valor1 * ula_valor2;
            default:          ula_executou  = 1'b0;
        endcase
    end

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_checks++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, atual, esperado);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int baixo7);
        return 16'((op << 13) | (rd << 10) | (rs1 << 7) | (baixo7 & 'h7F));
    endfunction

    function automatic logic [15:0] enc_load(input int rd, input int imm10);
        return 16'((rd << 10) | (imm10 & 'h3FF));
    endfunction

    // Returns {executed, value} from the instruction semantics.
    function automatic logic [16:0] model_eval(input logic [15:0] ins);
        longint a, b, i7, i10, r;
        a   = longint'(mregs[ins[9:7]]);
        b   = longint'(mregs[ins[6:4]]);
        i7  = longint'(ins[6:0]);
        if (i7 >= 64) i7 -= 128;
        i10 = longint'(ins[9:0]);
        if (i10 >= 512) i10 -= 1024;
        case (int'(ins[15:13]))
            0: r = i10;
            1: r = a + b;
            2: r = a + i7;
            3: r = a - b;
            4: r = a - i7;
            5: r = a * b;
            default: return 17'h0;
        endcase
        return {1'b1, 16'(r)};
    endfunction

    task automatic ler(input logic [2:0] a, output logic [15:0] d);
        leitura_end = a;
        #1;
        d = leitura_dado;
    endtask

    task automatic check_all_regs(input string tag);
        logic [15:0] d;
        for (int i = 0; i < 8; i++) begin
            ler(3'(i), d);
            check($sformatf("%s R%0d", tag, i), 32'(d), 32'(mregs[i]));
        end
    endtask

    // Issues one instruction at cycle 0 and follows it to its end.
    // Returns with the bench at cycle 4 (done) or cycle 3 (error).
    task automatic run_instr(input logic [15:0] ins, input string tag,
                             output logic ok_obs, output logic [15:0] val_obs);
        logic [16:0] ref_res;
        logic [2:0]  rd;
        logic [15:0] antigo, lido;
        int          fim_cyc;
        logic        viu_ok;
        ref_res = model_eval(ins);
        rd      = ins[12:10];
        antigo  = mregs[rd];
        check({tag, " pronto c0"}, 32'(instr_pronto), 32'd1);
        instr_valido = 1'b1;
        instrucao    = ins;
        fim_cyc = -1;
        viu_ok  = 1'b0;
        val_obs = '0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            instr_valido = 1'b0;
            check({tag, " pulsos exclusivos"}, 32'(concluido & erro_opcode), 32'd0);
            if (concluido || erro_opcode) begin
                fim_cyc = c;
                viu_ok  = concluido;
                break;
            end
        end
        ok_obs = viu_ok;
        check({tag, " ciclo de fim"}, 32'(fim_cyc), 32'd3);
        check({tag, " executou"}, 32'(viu_ok), 32'(ref_res[16]));
        if (fim_cyc == 3) begin
            check({tag, " pronto c3"}, 32'(instr_pronto), 32'(!ref_res[16]));
            ler(rd, lido);
            check({tag, " leitura c3 antiga"}, 32'(lido), 32'(antigo));
            if (viu_ok) begin
                val_obs = wb_valor;
                check({tag, " wb_destino"}, 32'(wb_destino), 32'(rd));
                check({tag, " wb_valor"}, 32'(wb_valor), 32'(ref_res[15:0]));
                mregs[rd] = ref_res[15:0];
                @(posedge clk); #1;
                check({tag, " concluido c4"}, 32'(concluido), 32'd0);
                check({tag, " pronto c4"}, 32'(instr_pronto), 32'd1);
                ler(rd, lido);
                check({tag, " leitura c4"}, 32'(lido), 32'(mregs[rd]));
            end
        end
    endtask

    typedef struct {
        logic [15:0] ins;
        logic        erro;
        logic [15:0] valor;
    } vetor_t;

    vetor_t tab [7];

    initial begin
        logic        ok;
        logic [15:0] val;
        int          n_erro;

        tab[0] = '{16'h0405, 1'b0, 16'h0005};                 // LOAD r1,#5
        tab[1] = '{16'h0BFD, 1'b0, 16'hFFFD};                 // LOAD r2,#-3
        tab[2] = '{enc(1, 3, 1, 2 << 4), 1'b0, 16'h0002};     // ADD r3,r1,r2
        tab[3] = '{enc(5, 4, 1, 2 << 4), 1'b0, 16'hFFF1};     // MUL r4,r1,r2
        tab[4] = '{enc(2, 1, 1, -64),    1'b0, 16'hFFC5};     // ADDI r1,r1,#-64
        tab[5] = '{enc(4, 5, 0, 1),      1'b0, 16'hFFFF};     // SUBI r5,r0,#1
        tab[6] = '{enc(6, 2, 1, 2 << 4), 1'b1, 16'h0000};     // undefined 110

        for (int i = 0; i < 8; i++) mregs[i] = '0;
        reset        = 1'b1;
        instr_valido = 1'b0;
        instrucao    = '0;
        leitura_end  = '0;

        @(posedge clk); #1;
        check("reset pronto", 32'(instr_pronto), 32'd1);
        check("reset concluido", 32'(concluido), 32'd0);
        check("reset erro", 32'(erro_opcode), 32'd0);
        check("reset wb_destino", 32'(wb_destino), 32'd0);
        check("reset wb_valor", 32'(wb_valor), 32'd0);
        check("reset ula_opcode", 32'(ula_opcode), 32'd0);
        check("reset ula_valor1", 32'(ula_valor1), 32'd0);
        check("reset ula_valor2", 32'(ula_valor2), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        check_all_regs("reset");

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            run_instr(tab[i].ins, $sformatf("tab%0d", i), ok, val);
            check($sformatf("tab%0d status", i), 32'(ok), 32'(!tab[i].erro));
            check($sformatf("tab%0d valor", i), 32'(val), 32'(tab[i].valor));
        end
        check_all_regs("tabela");

        // Repeated squaring wraps modulo 2^16.
        run_instr(enc_load(1, 511), "load511", ok, val);
        for (int i = 0; i < 4; i++) begin
            run_instr(enc(5, 1, 1, 1 << 4), $sformatf("mul_quad%0d", i), ok, val);
        end

        // Undefined opcode with instr_valido held high: re-accepted at c3.
        begin
            logic [15:0] ins_inv;
            ins_inv = enc(7, 7, 1, 2 << 4);
            n_erro  = 0;
            check("hold pronto c0", 32'(instr_pronto), 32'd1);
            instr_valido = 1'b1;
            instrucao    = ins_inv;
            for (int c = 1; c <= 6; c++) begin
                @(posedge clk); #1;
                if (c == 4) instr_valido = 1'b0;
                if (erro_opcode) n_erro++;
                check($sformatf("hold pronto c%0d", c), 32'(instr_pronto), 32'(c == 3 || c == 6));
                check($sformatf("hold erro c%0d", c), 32'(erro_opcode), 32'(c == 3 || c == 6));
                check($sformatf("hold concluido c%0d", c), 32'(concluido), 32'd0);
            end
            check("hold numero de erros", 32'(n_erro), 32'd2);
            check_all_regs("hold");
        end

        // instr_valido pulsed while busy is ignored.
        begin
            logic [16:0] esperado;
            logic [15:0] d;
            esperado     = model_eval(enc(1, 7, 1, 2 << 4));
            instr_valido = 1'b1;
            instrucao    = enc(1, 7, 1, 2 << 4);
            @(posedge clk); #1;
            instrucao = enc_load(6, 100);
            check("ocupado pronto c1", 32'(instr_pronto), 32'd0);
            @(posedge clk); #1;
            check("ocupado pronto c2", 32'(instr_pronto), 32'd0);
            @(posedge clk); #1;
            instr_valido = 1'b0;
            check("ocupado concluido c3", 32'(concluido), 32'd1);
            check("ocupado wb_destino", 32'(wb_destino), 32'd7);
            check("ocupado wb_valor", 32'(wb_valor), 32'(esperado[15:0]));
            mregs[7] = esperado[15:0];
            @(posedge clk); #1;
            check("ocupado pronto c4", 32'(instr_pronto), 32'd1);
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                check($sformatf("ocupado sem concluido %0d", c), 32'(concluido), 32'd0);
            end
            ler(3'd6, d);
            check("ocupado R6 intacto", 32'(d), 32'(mregs[6]));
        end

        // Randomized instructions against the model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            run_instr({op, 13'($urandom)}, $sformatf("rand%0d", i), ok, val);
        end
        check_all_regs("aleatorio");

        // Reset during EXECUTA aborts the instruction and clears everything.
        instr_valido = 1'b1;
        instrucao    = enc(1, 3, 1, 2 << 4);
        @(posedge clk); #1;
        instr_valido = 1'b0;
        check("abort pronto c1", 32'(instr_pronto), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        check("abort concluido", 32'(concluido), 32'd0);
        check("abort erro", 32'(erro_opcode), 32'd0);
        check("abort pronto", 32'(instr_pronto), 32'd1);
        check("abort wb_valor", 32'(wb_valor), 32'd0);
        check("abort ula_valor1", 32'(ula_valor1), 32'd0);
        check_all_regs("abort");
        @(posedge clk); #1;
        check("abort concluido depois", 32'(concluido), 32'd0);
        run_instr(16'h0405, "pos_abort", ok, val);
        check("pos_abort valor", 32'(val), 32'h5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multi-cycle control unit that drives the `ula` arithmetic block from the issuing side. It accepts one 16-bit instruction at a time through a valid/ready handshake and decodes opcode, registers and immediate. It reads operands from an internal 8×16 register file, presents them to the ALU, captures `resultado` when `executou` is asserted, and writes the value back. It sits between the instruction source (test bench or future fetch stage) and the ALU.

## Interface
- `LARGURA`, 16, data width of registers and ALU operands; instruction width is fixed at 16.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `instr_valido`  in  1  instruction present on `instrucao`.
- `instrucao`  in  16  [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2; [6:0] signed imm7 (ADDI/SUBI); [9:0] signed imm10 (LOAD).
- `instr_pronto`  out  1  unit can accept an instruction this cycle.
- `ula_opcode`  out  3  opcode to ALU.
- `ula_valor1`, `ula_valor2`  out  LARGURA  signed operands to ALU.
- `ula_resultado`  in  LARGURA  ALU result (combinational from ALU).
- `ula_executou`  in  1  ALU recognised the opcode.
- `concluido`  out  1  one-cycle pulse: write-back done.
- `erro_opcode`  out  1  one-cycle pulse: ALU rejected the opcode, nothing written.
- `wb_destino`  out  3  rd of last completed instruction.
- `wb_valor`  out  LARGURA  value written by last completed instruction.
- `leitura_end`  in  3  debug read address.
- `leitura_dado`  out  LARGURA  combinational register-file read of `leitura_end`.

## Operation
- Opcodes: LOAD=000, ADD=001, ADDI=010, SUB=011, SUBI=100, MUL=101; 110/111 undefined.
- Operand selection: ADD/SUB/MUL valor1=R[rs1], valor2=R[rs2]; ADDI/SUBI valor1=R[rs1], valor2=sext(imm7); LOAD valor1=0, valor2=sext(imm10); undefined opcodes valor1=R[rs1], valor2=R[rs2].
- FSM states:
  - OCIOSO: `instr_pronto`=1; `instr_valido`=1 latches `instrucao` → DECODIFICA.
  - DECODIFICA: register the operands → EXECUTA.
  - EXECUTA: drive `ula_*`, then sample `ula_resultado`/`ula_executou`. executou=1 → ESCRITA; executou=0 → OCIOSO with `erro_opcode` pulse.
  - ESCRITA: R[rd]←result; `wb_destino`/`wb_valor` updated; `concluido` pulse → OCIOSO.
- `instr_pronto`=0 in every state except OCIOSO; `instr_valido` is ignored outside OCIOSO.
- Arithmetic is two's complement modulo 2^LARGURA. MUL keeps the low LARGURA bits. Sign extension is taken from imm bit 6 or bit 9.
- All 8 registers are writable; no hard-wired zero register. rd may equal rs1 or rs2; operands are read before the write.
- `ula_opcode`/`ula_valor*` hold their last driven values outside EXECUTA. The ALU reads them only in EXECUTA.
- Reset values: state OCIOSO, all registers 0, `instr_pronto`=1 from the first cycle after reset, `concluido`=0, `erro_opcode`=0, `wb_destino`=0, `wb_valor`=0, `ula_opcode`=000, `ula_valor1`=`ula_valor2`=0.
- Reset in any state aborts the instruction in flight: no write, no pulse, register file cleared.

## Timing
- Accept edge = cycle 0 (OCIOSO with `instr_valido`=1).
- DECODIFICA in cycle 1, EXECUTA in cycle 2, ESCRITA in cycle 3.
- `concluido` and `wb_*` are valid during cycle 3. The written register is visible on `leitura_dado` from cycle 4.
- Error path: `erro_opcode` is high in cycle 3 with state OCIOSO, so the next instruction can be accepted in cycle 3.
- Normal path: next acceptance no earlier than cycle 4. Throughput is 1 instruction per 4 cycles (3 on error).
- A debug read of the register being written in the same cycle returns the old value (write-first is not required).
- `concluido` and `erro_opcode` are never high together.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants (shared with `ula`);
  - FSM state encoding;
  - instruction field positions and immediate widths;
  - register address width (3).
- Sub-module `banco_registradores`: 8×LARGURA, one synchronous write port, two combinational read ports for operands and one for debug, synchronous reset clear.

## Test plan
- Reset, then LOAD r1,#5 (0x0405) → `concluido` in cycle 3, `wb_destino`=1, `wb_valor`=5, `leitura_dado`(1)=5 from cycle 4.
- LOAD r1,#5; LOAD r2,#-3 (0x0BFD); ADD r3,r1,r2; MUL r4,r1,r2 → R3=2, R4=-15 (0xFFF1).
- ADDI r1,r1,#-64 with R1=5 → R1=-59 (0xFFC5). SUBI r5,r0,#1 → R5=0xFFFF.
- LOAD r1,#511, then MUL r1,r1,r1 repeatedly → low-16-bit wrap checked against a software model.
- Opcode 111 with `instr_valido` held high → `erro_opcode` pulses once, no register changes, `instr_pronto` returns in cycle 3, the held instruction is re-accepted.
- Assert `reset` in EXECUTA of ADD r3 → no `concluido`, all registers 0, `instr_pronto`=1 the cycle after reset deasserts; `instr_valido` pulsed during a busy state is ignored.
